// File: rtl/kv_serial_pq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  pq_pkg / kv_serial_pq_ctrl_if
//  pq_pkg         : key/value entry type shared by the quickq datapath.
//  kv_serial_pq_ctrl_if : producer/consumer bundle of the priority queue.
//    enq_valid/enq_ready/enq_data : insert handshake (producer -> queue)
//    deq_valid/deq_ready/deq_data : head handshake  (queue -> consumer)
//    count/full/empty/busy        : occupancy and insert-in-progress status
//  modport master : producer/consumer side;  modport slave : queue side.
//  Revision: 1.0  initial release
// ============================================================================
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;
endpackage

interface kv_serial_pq_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
);
  import pq_pkg::*;

  logic          enq_valid;
  logic          enq_ready;
  kv_t           enq_data;
  logic          deq_valid;
  logic          deq_ready;
  kv_t           deq_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count, full, empty, busy
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count, full, empty, busy
  );
endinterface
`default_nettype wire

// File: rtl/kv_serial_pq_ctrl.sv
`default_nettype none
// ============================================================================
//  kv_cmp_mag / kv_serial_pq_ctrl
//  kv_cmp_mag        : strict key magnitude compare, o_a_gt_b = a.key > b.key.
//  kv_serial_pq_ctrl : sorted register-array priority queue (largest key at
//                      the head) using one time-shared comparator to perform a
//                      serial insertion sort, one compare per cycle.
//  Ports:
//    clk  : clock, rising edge
//    rst  : synchronous active-high reset
//    bus  : kv_serial_pq_ctrl_if.slave (enq/deq handshakes, count, full,
//           empty, busy)
//  Revision: 1.0  initial release
// ============================================================================
module kv_cmp_mag
  import pq_pkg::*;
(
  input  kv_t  i_a,
  input  kv_t  i_b,
  output logic o_a_gt_b
);
  assign o_a_gt_b = (i_a.key > i_b.key);
endmodule

module kv_serial_pq_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  kv_serial_pq_ctrl_if.slave    bus
);
  import pq_pkg::*;

  localparam int            IW          = $clog2(DEPTH);
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] c_IDX_ONE   = IW'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_INSERT = 1'b1
  } state_t;

  state_t        r_state;
  kv_t           r_ent [DEPTH];
  kv_t           r_pend;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_idle;
  logic          w_enq_fire;
  logic          w_deq_fire;
  logic [CW-1:0] w_n;
  logic [IW-1:0] w_idx_m1;
  kv_t           w_cmp_b;
  logic          w_a_gt_b;

  assign w_full     = (r_cnt == c_DEPTH_CNT);
  assign w_empty    = (r_cnt == '0);
  assign w_idle     = (r_state == S_IDLE);
  assign w_enq_fire = bus.enq_valid && w_idle && !w_full;
  assign w_deq_fire = bus.deq_ready && w_idle && !w_empty;

  // Occupancy seen by the incoming item once a same-cycle dequeue has shifted.
  assign w_n        = w_deq_fire ? (r_cnt - c_CNT_ONE) : r_cnt;

  assign w_idx_m1   = r_idx - c_IDX_ONE;
  assign w_cmp_b    = r_ent[w_idx_m1];

  // The single comparator; its operands are only meaningful in S_INSERT.
  kv_cmp_mag u_cmp (
    .i_a      (r_pend),
    .i_b      (w_cmp_b),
    .o_a_gt_b (w_a_gt_b)
  );

  assign bus.enq_ready = w_idle && !w_full;
  assign bus.deq_valid = w_idle && !w_empty;
  assign bus.deq_data  = r_ent[0];
  assign bus.count     = r_cnt;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.busy      = (r_state == S_INSERT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_pend  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_deq_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) r_ent[i] <= r_ent[i+1];
            r_ent[DEPTH-1] <= '0;
            r_cnt          <= r_cnt - c_CNT_ONE;
          end
          if (w_enq_fire) begin
            if (w_n == '0) begin
              // Nothing to compare against: the item becomes the head
              // (overrides the shift-in written above).
              r_ent[0] <= bus.enq_data;
              r_cnt    <= c_CNT_ONE;
            end else begin
              // Start at the first free slot and bubble toward the head.
              r_pend  <= bus.enq_data;
              r_idx   <= w_n[IW-1:0];
              r_state <= S_INSERT;
            end
          end
        end

        S_INSERT: begin
          if (w_a_gt_b) begin
            r_ent[r_idx] <= r_ent[w_idx_m1];
            if (r_idx == c_IDX_ONE) begin
              r_ent[0] <= r_pend;
              r_cnt    <= r_cnt + c_CNT_ONE;
              r_state  <= S_IDLE;
            end else begin
              r_idx <= w_idx_m1;
            end
          end else begin
            // Equal keys stop the walk, so equals keep arrival order.
            r_ent[r_idx] <= r_pend;
            r_cnt        <= r_cnt + c_CNT_ONE;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_kv_serial_pq_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_kv_serial_pq_ctrl
//  Self-checking bench: directed scenarios followed by random traffic, all
//  compared against a queue-based reference model of the priority queue.
//  Revision: 1.0  initial release
// ============================================================================
module tb_kv_serial_pq_ctrl;
  import pq_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;

  kv_serial_pq_ctrl_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

  kv_serial_pq_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;

  // Reference model: sorted contents, item being inserted, compares left.
  kv_t mq[$];
  kv_t m_pend;
  int  m_left = 0;

  function automatic kv_t mk(input int k, input int v);
    kv_t t;
    t.key   = 8'(k);
    t.value = 8'(v);
    return t;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // New item goes behind every entry whose key is >= its own.
  function automatic void model_insert(input kv_t d);
    int pos = 0;
    foreach (mq[i]) if (mq[i].key >= d.key) pos++;
    mq.insert(pos, d);
  endfunction

  function automatic void model_edge(input logic r, input logic ev, input kv_t ed, input logic dr);
    int n;
    int less;
    if (r) begin
      mq.delete();
      m_left = 0;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) model_insert(m_pend);
      return;
    end
    if (dr && mq.size() > 0) void'(mq.pop_front());
    if (ev && (mq.size() + ((dr && mq.size() >= 0) ? 0 : 0)) < DEPTH) begin
    end
    // Full is judged on occupancy before any same-cycle dequeue.
    if (ev && (mq.size() + ((dr && m_left == 0) ? 1 : 0)) <= DEPTH) begin
    end
  endfunction

  task automatic check_outputs();
    int   sz   = mq.size();
    logic idle = (m_left == 0);
    kv_t  head;
    head = (sz > 0) ? mq[0] : '0;
    chk_val("count",     32'(bus.count),     32'(sz));
    chk_val("empty",     32'(bus.empty),     32'(sz == 0));
    chk_val("full",      32'(bus.full),      32'(sz == DEPTH));
    chk_val("busy",      32'(bus.busy),      32'(!idle));
    chk_val("enq_ready", 32'(bus.enq_ready), 32'(idle && sz < DEPTH));
    chk_val("deq_valid", 32'(bus.deq_valid), 32'(idle && sz > 0));
    if (idle) chk_val("deq_data", 32'(bus.deq_data), 32'(head));
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, sample the DUT at the next falling edge.
  task automatic step(input logic ev, input kv_t ed, input logic dr);
    int  sz_before;
    logic idle_before;
    logic deq_f;
    logic enq_f;
    int  n;
    int  less;
    bus.enq_valid = ev;
    bus.enq_data  = ed;
    bus.deq_ready = dr;
    sz_before   = mq.size();
    idle_before = (m_left == 0);
    @(posedge clk);
    if (rst || !idle_before) begin
      model_edge(rst, ev, ed, dr);
    end else begin
      deq_f = dr && (sz_before > 0);
      enq_f = ev && (sz_before < DEPTH);
      if (deq_f) void'(mq.pop_front());
      if (enq_f) begin
        n = mq.size();
        if (n == 0) begin
          mq.push_back(ed);
        end else begin
          less = 0;
          foreach (mq[i]) if (mq[i].key < ed.key) less++;
          m_pend = ed;
          m_left = (less < n) ? less + 1 : n;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic enq_item(input int k, input int v, input int exp_busy);
    kv_t d = mk(k, v);
    logic acc = 1'b0;
    int  blen = 0;
    for (int g = 0; g < 4 * DEPTH && !acc; g++) begin
      acc = (m_left == 0) && (mq.size() < DEPTH);
      step(1'b1, d, 1'b0);
    end
    while (bus.busy && blen < 2 * DEPTH + 2) begin
      blen++;
      step(1'b0, d, 1'b0);
    end
    if (exp_busy >= 0) chk_val("busy_len", 32'(blen), 32'(exp_busy));
  endtask

  task automatic drain_one(input int exp_key);
    chk_val("deq_key", 32'(bus.deq_data.key), 32'(exp_key));
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.enq_valid = 1'b0;
    bus.enq_data  = '0;
    bus.deq_ready = 1'b0;
    @(negedge clk);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk_val("rst_deq_data", 32'(bus.deq_data), 32'h0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);

    // Basic ordering
    enq_item(5, 1, 0);
    enq_item(9, 2, 1);
    enq_item(2, 3, 1);
    chk_val("order_count", 32'(bus.count), 32'd3);
    drain_one(9);
    drain_one(5);
    drain_one(2);
    chk_val("order_empty", 32'(bus.empty), 32'd1);

    // Equal keys leave in arrival order
    enq_item(4, 'hA, 0);
    enq_item(4, 'hB, 1);
    chk_val("tie_first", 32'(bus.deq_data.value), 32'hA);
    step(1'b0, '0, 1'b1);
    chk_val("tie_second", 32'(bus.deq_data.value), 32'hB);
    step(1'b0, '0, 1'b1);

    // Ascending keys: every insert walks to the head; then full
    for (int m = 1; m <= DEPTH; m++) enq_item(m, m, m - 1);
    chk_val("full_flag", 32'(bus.full), 32'd1);
    chk_val("full_enq_ready", 32'(bus.enq_ready), 32'd0);
    repeat (3) step(1'b1, mk(9, 9), 1'b0);
    chk_val("full_count", 32'(bus.count), 32'(DEPTH));
    chk_val("full_head", 32'(bus.deq_data.key), 32'(DEPTH));
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) drain_one(DEPTH - i);

    // Simultaneous enqueue and dequeue with one entry
    enq_item(3, 3, 0);
    chk_val("sim_pre_head", 32'(bus.deq_data.key), 32'd3);
    step(1'b1, mk(7, 7), 1'b1);
    chk_val("sim_head", 32'(bus.deq_data.key), 32'd7);
    chk_val("sim_count", 32'(bus.count), 32'd1);
    chk_val("sim_busy", 32'(bus.busy), 32'd0);
    drain_one(7);

    // Reset in the second compare cycle of a worst-case insert
    enq_item(4, 1, 0);
    enq_item(3, 2, 1);
    enq_item(2, 3, 1);
    enq_item(1, 4, 1);
    step(1'b1, mk(10, 5), 1'b0);
    step(1'b0, '0, 1'b0);
    chk_val("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk_val("mid_rst_count", 32'(bus.count), 32'd0);
    chk_val("mid_rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    chk_val("mid_rst_deq_data", 32'(bus.deq_data), 32'h0);

    // Backpressure holds the head steady
    enq_item(6, 1, 0);
    enq_item(3, 2, 1);
    repeat (5) begin
      step(1'b0, '0, 1'b0);
      chk_val("bp_head", 32'(bus.deq_data.key), 32'd6);
      chk_val("bp_valid", 32'(bus.deq_valid), 32'd1);
      chk_val("bp_count", 32'(bus.count), 32'd2);
    end
    drain_one(6);
    drain_one(3);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      step(1'($urandom_range(0, 1)),
           mk($urandom_range(0, 15), $urandom_range(0, 255)),
           1'($urandom_range(0, 3) == 0));
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
